lcd_timing_pip: RTL and testbench

Parametrised LCD raster timing generator with NUM_WIN runtime-programmable picture-in-picture windows. It generates the sync and DE timing and issues a per-window pixel request with window-local coordinates. It composites the returned pixel data by fixed priority onto a background colour. Window geometry is double-buffered and swapped only at the frame boundary, so moves never tear. It sits between the frame-buffer/sensor readers and the LCD pins.

---
 rtl/lcd_timing_pip.sv | 233 +++++++++++++++++++++++
 tb/tb_lcd_timing_pip.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_pip.sv
// LCD raster timing generator with double-buffered picture-in-picture windows.
// Three-stage pipeline: window request, pixel fetch, priority composite onto the pins.
module lcd_timing_pip #(
    parameter int H_SYNC  = 2,
    parameter int H_BACK  = 44,
    parameter int H_DISP  = 800,
    parameter int H_FRONT = 210,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 22,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 22,
    parameter int NUM_WIN = 2,
    parameter int CW      = 11,
    parameter int DW      = 24,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter logic [DW-1:0] BG_COLOR = {DW{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_win,
    input  logic [CW-1:0]         cfg_x,
    input  logic [CW-1:0]         cfg_y,
    input  logic [CW-1:0]         cfg_w,
    input  logic [CW-1:0]         cfg_h,
    input  logic                  cfg_en,
    output logic [NUM_WIN-1:0]    win_req,
    output logic [NUM_WIN*CW-1:0] win_x,
    output logic [NUM_WIN*CW-1:0] win_y,
    input  logic [NUM_WIN*DW-1:0] pix_in,
    output logic                  lcd_clk,
    output logic                  lcd_de,
    output logic                  lcd_blank_n,
    output logic                  lcd_hsync,
    output logic                  lcd_vsync,
    output logic [DW-1:0]         lcd_rgb,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT0  = H_SYNC + H_BACK;
    localparam int V_ACT0  = V_SYNC + V_BACK;

    logic [CW-1:0]         h_r, v_r;
    logic [CW-1:0]         pend_x_r [NUM_WIN];
    logic [CW-1:0]         pend_y_r [NUM_WIN];
    logic [CW-1:0]         pend_w_r [NUM_WIN];
    logic [CW-1:0]         pend_h_r [NUM_WIN];
    logic [NUM_WIN-1:0]    pend_en_r;
    logic [CW-1:0]         act_x_r  [NUM_WIN];
    logic [CW-1:0]         act_y_r  [NUM_WIN];
    logic [CW-1:0]         act_w_r  [NUM_WIN];
    logic [CW-1:0]         act_h_r  [NUM_WIN];
    logic [NUM_WIN-1:0]    act_en_r;

    logic                  hs_s, vs_s, de_s, fs_s, last_s;
    logic [CW-1:0]         ha_s, va_s;
    logic [NUM_WIN-1:0]    hit_s, wsel_s;
    logic [NUM_WIN*CW-1:0] lx_s, ly_s;
    logic [DW-1:0]         rgb_s;

    logic [NUM_WIN-1:0]    win_req_r, req2_r;
    logic [NUM_WIN*CW-1:0] win_x_r, win_y_r;
    logic                  hs1_r, vs1_r, de1_r, fs1_r;
    logic                  hs2_r, vs2_r, de2_r, fs2_r;
    logic                  lcd_de_r, lcd_hsync_r, lcd_vsync_r, frame_start_r;
    logic [DW-1:0]         lcd_rgb_r;

    // Highest-index requesting window wins; otherwise background inside the active area.
    function automatic logic [DW-1:0] pick_pixel(input logic [NUM_WIN-1:0] req,
                                                 input logic [NUM_WIN*DW-1:0] pix,
                                                 input logic de);
        logic [DW-1:0] px;
        px = de ? BG_COLOR : {DW{1'b0}};
        for (int i = 0; i < NUM_WIN; i++) begin
            if (req[i]) begin
                px = pix[i*DW +: DW];
            end
        end
        return px;
    endfunction

    // Raster counters: h wraps at H_TOTAL, v advances on each h wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_r <= {CW{1'b0}};
            v_r <= {CW{1'b0}};
        end else if (h_r == CW'(H_TOTAL - 1)) begin
            h_r <= {CW{1'b0}};
            v_r <= (v_r == CW'(V_TOTAL - 1)) ? {CW{1'b0}} : v_r + CW'(1);
        end else begin
            h_r <= h_r + CW'(1);
        end
    end

    // Raw timing and window hit test at the current counter position.
    always_comb begin
        hs_s   = (h_r < CW'(H_SYNC));
        vs_s   = (v_r < CW'(V_SYNC));
        de_s   = (h_r >= CW'(H_ACT0)) && (h_r < CW'(H_ACT0 + H_DISP)) &&
                 (v_r >= CW'(V_ACT0)) && (v_r < CW'(V_ACT0 + V_DISP));
        fs_s   = (h_r == {CW{1'b0}}) && (v_r == {CW{1'b0}});
        last_s = (h_r == CW'(H_TOTAL - 1)) && (v_r == CW'(V_TOTAL - 1));
        ha_s   = h_r - CW'(H_ACT0);
        va_s   = v_r - CW'(V_ACT0);
        hit_s  = {NUM_WIN{1'b0}};
        wsel_s = {NUM_WIN{1'b0}};
        lx_s   = {(NUM_WIN*CW){1'b0}};
        ly_s   = {(NUM_WIN*CW){1'b0}};
        for (int i = 0; i < NUM_WIN; i++) begin
            // Extra top bit keeps x+w from wrapping near the coordinate limit.
            hit_s[i] = act_en_r[i] && de_s &&
                       ({1'b0, ha_s} >= {1'b0, act_x_r[i]}) &&
                       ({1'b0, ha_s} <  ({1'b0, act_x_r[i]} + {1'b0, act_w_r[i]})) &&
                       ({1'b0, va_s} >= {1'b0, act_y_r[i]}) &&
                       ({1'b0, va_s} <  ({1'b0, act_y_r[i]} + {1'b0, act_h_r[i]}));
            lx_s[i*CW +: CW] = ha_s - act_x_r[i];
            ly_s[i*CW +: CW] = va_s - act_y_r[i];
            wsel_s[i] = cfg_we && (cfg_win == 3'(i));
        end
    end

    // Geometry shadow registers; pending becomes active only on the last cycle of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                pend_x_r[i] <= {CW{1'b0}};
                pend_y_r[i] <= {CW{1'b0}};
                act_x_r[i]  <= {CW{1'b0}};
                act_y_r[i]  <= {CW{1'b0}};
                pend_w_r[i] <= (i == 0) ? CW'(H_DISP) : {CW{1'b0}};
                pend_h_r[i] <= (i == 0) ? CW'(V_DISP) : {CW{1'b0}};
                act_w_r[i]  <= (i == 0) ? CW'(H_DISP) : {CW{1'b0}};
                act_h_r[i]  <= (i == 0) ? CW'(V_DISP) : {CW{1'b0}};
                pend_en_r[i] <= (i == 0);
                act_en_r[i]  <= (i == 0);
            end
        end else begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (wsel_s[i]) begin
                    pend_x_r[i]  <= cfg_x;
                    pend_y_r[i]  <= cfg_y;
                    pend_w_r[i]  <= cfg_w;
                    pend_h_r[i]  <= cfg_h;
                    pend_en_r[i] <= cfg_en;
                end
                if (last_s) begin
                    act_x_r[i]  <= wsel_s[i] ? cfg_x  : pend_x_r[i];
                    act_y_r[i]  <= wsel_s[i] ? cfg_y  : pend_y_r[i];
                    act_w_r[i]  <= wsel_s[i] ? cfg_w  : pend_w_r[i];
                    act_h_r[i]  <= wsel_s[i] ? cfg_h  : pend_h_r[i];
                    act_en_r[i] <= wsel_s[i] ? cfg_en : pend_en_r[i];
                end
            end
        end
    end

    // Stage 1: window requests with local coordinates, timing delayed alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_req_r <= {NUM_WIN{1'b0}};
            win_x_r   <= {(NUM_WIN*CW){1'b0}};
            win_y_r   <= {(NUM_WIN*CW){1'b0}};
            hs1_r     <= 1'b0;
            vs1_r     <= 1'b0;
            de1_r     <= 1'b0;
            fs1_r     <= 1'b0;
        end else begin
            win_req_r <= hit_s;
            for (int i = 0; i < NUM_WIN; i++) begin
                win_x_r[i*CW +: CW] <= hit_s[i] ? lx_s[i*CW +: CW] : {CW{1'b0}};
                win_y_r[i*CW +: CW] <= hit_s[i] ? ly_s[i*CW +: CW] : {CW{1'b0}};
            end
            hs1_r <= hs_s;
            vs1_r <= vs_s;
            de1_r <= de_s;
            fs1_r <= fs_s;
        end
    end

    // Stage 2: hold requests while the readers return pixel data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req2_r <= {NUM_WIN{1'b0}};
            hs2_r  <= 1'b0;
            vs2_r  <= 1'b0;
            de2_r  <= 1'b0;
            fs2_r  <= 1'b0;
        end else begin
            req2_r <= win_req_r;
            hs2_r  <= hs1_r;
            vs2_r  <= vs1_r;
            de2_r  <= de1_r;
            fs2_r  <= fs1_r;
        end
    end

    // Priority composite of the returned pixels.
    always_comb begin
        rgb_s = pick_pixel(req2_r, pix_in, de2_r);
    end

    // Stage 3: registered LCD pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_de_r      <= 1'b0;
            lcd_hsync_r   <= ~HS_POL;
            lcd_vsync_r   <= ~VS_POL;
            lcd_rgb_r     <= {DW{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            lcd_de_r      <= de2_r;
            lcd_hsync_r   <= hs2_r ? HS_POL : ~HS_POL;
            lcd_vsync_r   <= vs2_r ? VS_POL : ~VS_POL;
            lcd_rgb_r     <= rgb_s;
            frame_start_r <= fs2_r;
        end
    end

    assign win_req     = win_req_r;
    assign win_x       = win_x_r;
    assign win_y       = win_y_r;
    assign lcd_clk     = clk;
    assign lcd_de      = lcd_de_r;
    assign lcd_blank_n = lcd_de_r;
    assign lcd_hsync   = lcd_hsync_r;
    assign lcd_vsync   = lcd_vsync_r;
    assign lcd_rgb     = lcd_rgb_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_lcd_timing_pip.sv
// Bench for lcd_timing_pip on a 15x7 raster with two windows, random pixel data and a
// raster-position reference model.
module tb_lcd_timing_pip;

    localparam int CW = 11;
    localparam int DW = 24;
    localparam int HT = 15;
    localparam int VT = 7;
    localparam int FT = HT * VT;
    localparam logic [23:0] BG = 24'h0000FF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [2:0]    cfg_win;
    logic [CW-1:0] cfg_x, cfg_y, cfg_w, cfg_h;
    logic          cfg_en;
    logic [1:0]    win_req;
    logic [2*CW-1:0] win_x, win_y;
    logic [2*DW-1:0] pix_in;
    logic          lcd_clk, lcd_de, lcd_blank_n, lcd_hsync, lcd_vsync, frame_start;
    logic [DW-1:0] lcd_rgb;

    always #5 clk = ~clk;

    lcd_timing_pip #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .NUM_WIN(2), .CW(CW), .DW(DW), .HS_POL(1'b0), .VS_POL(1'b0), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_win(cfg_win),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_en(cfg_en),
        .win_req(win_req), .win_x(win_x), .win_y(win_y), .pix_in(pix_in),
        .lcd_clk(lcd_clk), .lcd_de(lcd_de), .lcd_blank_n(lcd_blank_n),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_rgb(lcd_rgb),
        .frame_start(frame_start)
    );

    typedef struct packed {
        logic hs, vs, de, fs;
        logic [1:0] req;
        logic [10:0] wx0, wx1, wy0, wy1;
    } rec_t;

    int checks = 0;
    int failures = 0;
    int n;
    int de_cnt, fs_cnt;
    rec_t d1, d2;
    int px[2], py[2], pw[2], ph[2];
    bit pe[2];
    int ax[2], ay[2], aw[2], ah[2];
    bit ae[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t model_at(input int p);
        rec_t r;
        int h, v, ha, va;
        bit hit;
        r  = '0;
        h  = p % HT;
        v  = (p / HT) % VT;
        ha = h - 5;
        va = v - 2;
        r.hs = (h < 2);
        r.vs = (v < 1);
        r.de = (h >= 5) && (h < 13) && (v >= 2) && (v < 6);
        r.fs = (p % FT) == 0;
        for (int i = 0; i < 2; i++) begin
            hit = ae[i] && r.de && ha >= ax[i] && ha < ax[i] + aw[i] &&
                  va >= ay[i] && va < ay[i] + ah[i];
            r.req[i] = hit;
            if (i == 0) begin
                r.wx0 = hit ? 11'(ha - ax[i]) : 11'd0;
                r.wy0 = hit ? 11'(va - ay[i]) : 11'd0;
            end else begin
                r.wx1 = hit ? 11'(ha - ax[i]) : 11'd0;
                r.wy1 = hit ? 11'(va - ay[i]) : 11'd0;
            end
        end
        return r;
    endfunction

    task automatic reset_model();
        n  = 0;
        d1 = '0;
        d2 = '0;
        for (int i = 0; i < 2; i++) begin
            px[i] = 0; py[i] = 0;
            pw[i] = (i == 0) ? 8 : 0;
            ph[i] = (i == 0) ? 4 : 0;
            pe[i] = (i == 0);
            ax[i] = px[i]; ay[i] = py[i]; aw[i] = pw[i]; ah[i] = ph[i]; ae[i] = pe[i];
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   64'(win_req), 64'd0);
        chk({tag, "_wx"},    64'(win_x), 64'd0);
        chk({tag, "_wy"},    64'(win_y), 64'd0);
        chk({tag, "_de"},    64'(lcd_de), 64'd0);
        chk({tag, "_blank"}, 64'(lcd_blank_n), 64'd0);
        chk({tag, "_hs"},    64'(lcd_hsync), 64'd1);
        chk({tag, "_vs"},    64'(lcd_vsync), 64'd1);
        chk({tag, "_rgb"},   64'(lcd_rgb), 64'd0);
        chk({tag, "_fs"},    64'(frame_start), 64'd0);
    endtask

    // One clock: drive inputs, advance model, compare stage-1 and pin outputs.
    task automatic step(input bit we, input int win, input int x, input int y,
                        input int w, input int hh, input bit en);
        rec_t r;
        logic [47:0] pix;
        logic [23:0] e_rgb;
        r   = model_at(n);
        pix = 48'({$urandom, $urandom});
        pix_in  = pix;
        cfg_we  = we;
        cfg_win = 3'(win);
        cfg_x = 11'(x); cfg_y = 11'(y); cfg_w = 11'(w); cfg_h = 11'(hh); cfg_en = en;
        if (d2.req[1])      e_rgb = pix[47:24];
        else if (d2.req[0]) e_rgb = pix[23:0];
        else if (d2.de)     e_rgb = BG;
        else                e_rgb = 24'h0;
        if (we && win < 2) begin
            px[win] = x; py[win] = y; pw[win] = w; ph[win] = hh; pe[win] = en;
        end
        if (n % FT == FT - 1) begin
            for (int i = 0; i < 2; i++) begin
                ax[i] = px[i]; ay[i] = py[i]; aw[i] = pw[i]; ah[i] = ph[i]; ae[i] = pe[i];
            end
        end
        @(posedge clk);
        #1;
        chk("win_req", 64'(win_req), 64'(r.req));
        chk("win_x0", 64'(win_x[CW-1:0]), 64'(r.wx0));
        chk("win_x1", 64'(win_x[2*CW-1:CW]), 64'(r.wx1));
        chk("win_y0", 64'(win_y[CW-1:0]), 64'(r.wy0));
        chk("win_y1", 64'(win_y[2*CW-1:CW]), 64'(r.wy1));
        chk("lcd_de", 64'(lcd_de), 64'(d2.de));
        chk("lcd_blank_n", 64'(lcd_blank_n), 64'(d2.de));
        chk("lcd_hsync", 64'(lcd_hsync), d2.hs ? 64'd0 : 64'd1);
        chk("lcd_vsync", 64'(lcd_vsync), d2.vs ? 64'd0 : 64'd1);
        chk("lcd_rgb", 64'(lcd_rgb), 64'(e_rgb));
        chk("frame_start", 64'(frame_start), 64'(d2.fs));
        de_cnt += int'(lcd_de);
        fs_cnt += int'(frame_start);
        d2 = d1;
        d1 = r;
        n++;
        cfg_we = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic run_to(input int pos);
        while (n % FT != pos) step(1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_win = 3'd0; cfg_en = 1'b0;
        cfg_x = 11'd0; cfg_y = 11'd0; cfg_w = 11'd0; cfg_h = 11'd0;
        pix_in = 48'd0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle raster with the default full-screen window 0.
        de_cnt = 0;
        fs_cnt = 0;
        run(2 * FT);
        chk("de_two_frames", 64'(de_cnt), 64'd64);
        chk("fs_two_frames", 64'(fs_cnt), 64'd2);

        // Window 1 overlapping window 0.
        run_to(30);
        step(1'b1, 1, 2, 1, 3, 2, 1'b1);
        run_to(0);
        run(FT);

        // Window 0 off, window 1 clipped at the bottom-right corner.
        step(1'b1, 0, 0, 0, 8, 4, 1'b0);
        step(1'b1, 1, 6, 3, 5, 5, 1'b1);
        run_to(0);
        run(FT);

        // Mid-frame write, ignored index, and a write on the swap cycle.
        run_to(40);
        step(1'b1, 1, 0, 0, 8, 4, 1'b1);
        step(1'b1, 5, 1, 1, 1, 1, 1'b1);
        run_to(FT - 1);
        step(1'b1, 0, 3, 2, 2, 1, 1'b1);
        run(FT);

        // Random geometry traffic, including swap-cycle writes.
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < FT; c++) begin
                if ($urandom_range(0, 19) == 0 ||
                    (n % FT == FT - 1 && $urandom_range(0, 1) == 1)) begin
                    step(1'b1, $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 5),
                         $urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 3) != 0);
                end else begin
                    step(1'b0, 0, 0, 0, 0, 0, 1'b0);
                end
            end
        end

        // Reset mid-line with a pending write outstanding.
        run_to(50);
        step(1'b1, 1, 0, 0, 8, 4, 1'b1);
        run(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        @(posedge clk);
        #1;
        chk_reset("held");
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        run(2 * FT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
